// File: rtl/tk_pkg.sv
// rtl/tk_pkg.sv - shared limits, channel indices and BCD increment helper for time_keeper
package tk_pkg;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HR24_MAX = 8'h23;
  localparam logic [7:0] HR12_MAX = 8'h12;
  localparam logic [7:0] HR12_MIN = 8'h01;
  localparam int         SYNC_STAGES = 2;
  localparam int         NUM_CH      = 3;

  typedef enum logic [1:0] {
    CH_SEC = 2'd0,
    CH_MIN = 2'd1,
    CH_HR  = 2'd2
  } tk_chan_e;

  // Callers never pass a value at its limit, so only the low-digit carry matters.
  function automatic logic [7:0] bcd_inc(input logic [7:0] v);
    if (v[3:0] == 4'd9) begin
      return {v[7:4] + 4'd1, 4'd0};
    end
    return {v[7:4], v[3:0] + 4'd1};
  endfunction

endpackage

// File: rtl/bcd_counter.sv
// rtl/bcd_counter.sv - packed-BCD counter MIN_VAL..MAX_VAL with a one-cycle wrap pulse
module bcd_counter
  import tk_pkg::*;
#(
  parameter logic [7:0] MIN_VAL = 8'h00,
  parameter logic [7:0] MAX_VAL = 8'h59,
  parameter logic [7:0] RST_VAL = 8'h00
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc,
  output logic [7:0] value,
  output logic       wrap
);

  // wrap is high exactly in the cycle where value first shows MIN_VAL after MAX_VAL.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= RST_VAL;
      wrap  <= 1'b0;
    end else begin
      wrap <= 1'b0;
      if (inc) begin
        if (value == MAX_VAL) begin
          value <= MIN_VAL;
          wrap  <= 1'b1;
        end else begin
          value <= bcd_inc(value);
        end
      end
    end
  end

endmodule

// File: rtl/time_keeper.sv
// rtl/time_keeper.sv - independent BCD second/minute/hour counters driven by level requests
// Define TK_12H_EN for 01-12 hours with a pm flag; default is 00-23 with pm tied low.
module time_keeper
  import tk_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       clk_s,
  input  logic       clk_m,
  input  logic       clk_h,
  output logic [7:0] second,
  output logic [7:0] minute,
  output logic [7:0] hour,
  output logic       s_bit,
  output logic       m_bit,
  output logic       pm
);

  logic [NUM_CH-1:0]                   req;
  logic [SYNC_STAGES-1:0][NUM_CH-1:0]  sync_q;
  logic [NUM_CH-1:0]                   prev_q;
  logic [NUM_CH-1:0]                   strobe_q;
  logic                                hr_wrap_unused;

  assign req = {clk_h, clk_m, clk_s};

  // Flops reset high so a request held across reset release never looks like an edge.
  // The strobe is registered, giving the three-edge request-to-count latency.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q   <= '1;
      prev_q   <= '1;
      strobe_q <= '0;
    end else begin
      sync_q   <= {sync_q[SYNC_STAGES-2:0], req};
      prev_q   <= sync_q[SYNC_STAGES-1];
      strobe_q <= sync_q[SYNC_STAGES-1] & ~prev_q;
    end
  end

  bcd_counter #(.MIN_VAL(8'h00), .MAX_VAL(SEC_MAX), .RST_VAL(8'h00)) u_sec (
    .clk   (clk),
    .rst_n (rst),
    .inc   (strobe_q[CH_SEC]),
    .value (second),
    .wrap  (s_bit)
  );

  bcd_counter #(.MIN_VAL(8'h00), .MAX_VAL(MIN_MAX), .RST_VAL(8'h00)) u_min (
    .clk   (clk),
    .rst_n (rst),
    .inc   (strobe_q[CH_MIN]),
    .value (minute),
    .wrap  (m_bit)
  );

`ifdef TK_12H_EN
  bcd_counter #(.MIN_VAL(HR12_MIN), .MAX_VAL(HR12_MAX), .RST_VAL(HR12_MAX)) u_hr (
    .clk   (clk),
    .rst_n (rst),
    .inc   (strobe_q[CH_HR]),
    .value (hour),
    .wrap  (hr_wrap_unused)
  );

  // pm flips when the hour steps from 11 to 12, in the same cycle the hour updates.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pm <= 1'b0;
    end else if (strobe_q[CH_HR] && (hour == HR12_MAX - 8'h01)) begin
      pm <= ~pm;
    end
  end
`else
  bcd_counter #(.MIN_VAL(8'h00), .MAX_VAL(HR24_MAX), .RST_VAL(8'h00)) u_hr (
    .clk   (clk),
    .rst_n (rst),
    .inc   (strobe_q[CH_HR]),
    .value (hour),
    .wrap  (hr_wrap_unused)
  );

  assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb/tb_time_keeper.sv - self-checking bench for time_keeper (directed table, corner sequences, random vs model)
module tb_time_keeper;

`ifdef TK_12H_EN
  localparam bit MODE12 = 1'b1;
  localparam int HR_RST = 12;
`else
  localparam bit MODE12 = 1'b0;
  localparam int HR_RST = 0;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       clk_s = 1'b0;
  logic       clk_m = 1'b0;
  logic       clk_h = 1'b0;
  logic [7:0] second, minute, hour;
  logic       s_bit, m_bit, pm;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;
  int sb_cnt = 0;
  int mb_cnt = 0;

  time_keeper dut (
    .clk    (clk),
    .rst    (rst),
    .clk_s  (clk_s),
    .clk_m  (clk_m),
    .clk_h  (clk_h),
    .second (second),
    .minute (minute),
    .hour   (hour),
    .s_bit  (s_bit),
    .m_bit  (m_bit),
    .pm     (pm)
  );

  always #5 clk = ~clk;

  function automatic logic [7:0] bcd(input int v);
    return 8'((v / 10) * 16 + (v % 10));
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference model: an input level sampled high at edge k after being low at edge k-1
  // becomes a +1 three edges later.
  int       m_sec = 0;
  int       m_min = 0;
  int       m_hr  = HR_RST;
  bit       m_pm  = 1'b0;
  bit       m_sb  = 1'b0;
  bit       m_mb  = 1'b0;
  bit [2:0] smp [5];
  bit [2:0] rise;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_sec = 0; m_min = 0; m_hr = HR_RST; m_pm = 1'b0; m_sb = 1'b0; m_mb = 1'b0;
      foreach (smp[i]) smp[i] = 3'b111;
    end else begin
      for (int i = 4; i > 0; i--) smp[i] = smp[i-1];
      smp[0] = {clk_h, clk_m, clk_s};
      rise = smp[3] & ~smp[4];
      m_sb = 1'b0;
      m_mb = 1'b0;
      if (rise[0]) begin
        m_sec = (m_sec + 1) % 60;
        m_sb  = (m_sec == 0);
      end
      if (rise[1]) begin
        m_min = (m_min + 1) % 60;
        m_mb  = (m_min == 0);
      end
      if (rise[2]) begin
        if (MODE12) begin
          if (m_hr == 11) m_pm = !m_pm;
          m_hr = (m_hr == 12) ? 1 : m_hr + 1;
        end else begin
          m_hr = (m_hr + 1) % 24;
        end
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      chk("model_second", second, bcd(m_sec));
      chk("model_minute", minute, bcd(m_min));
      chk("model_hour",   hour,   bcd(m_hr));
      chk("model_s_bit",  s_bit,  m_sb);
      chk("model_m_bit",  m_bit,  m_mb);
      chk("model_pm",     pm,     m_pm);
      if (s_bit === 1'b1) sb_cnt++;
      if (m_bit === 1'b1) mb_cnt++;
    end
  end

  typedef struct {
    logic [2:0] req;
    int         reps;
    logic [7:0] sec;
    logic [7:0] min;
    logic [7:0] hr;
    logic       pmv;
    int         sb;
    int         mb;
  } vec_t;

  vec_t tbl [10];

  task automatic set_req(input logic [2:0] r);
    {clk_h, clk_m, clk_s} = r;
  endtask

  task automatic pulse(input logic [2:0] r);
    set_req(r);
    repeat (2) @(negedge clk);
    set_req(3'b000);
    repeat (2) @(negedge clk);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    errors++;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] h0;
    h0 = MODE12 ? 8'h12 : 8'h00;
    tbl[0] = '{3'b001,  9, 8'h10, 8'h00, h0, 1'b0, 0, 0};
    tbl[1] = '{3'b001, 49, 8'h59, 8'h00, h0, 1'b0, 0, 0};
    tbl[2] = '{3'b001,  1, 8'h00, 8'h00, h0, 1'b0, 1, 0};
    tbl[3] = '{3'b010, 59, 8'h00, 8'h59, h0, 1'b0, 0, 0};
    tbl[4] = '{3'b011,  1, 8'h01, 8'h00, h0, 1'b0, 0, 1};
    tbl[5] = '{3'b100, 11, 8'h01, 8'h00, 8'h11, 1'b0, 0, 0};
    tbl[6] = '{3'b100,  1, 8'h01, 8'h00, 8'h12, MODE12, 0, 0};
    tbl[7] = '{3'b100,  1, 8'h01, 8'h00, MODE12 ? 8'h01 : 8'h13, MODE12, 0, 0};
    tbl[8] = '{3'b100, 10, 8'h01, 8'h00, MODE12 ? 8'h11 : 8'h23, MODE12, 0, 0};
    tbl[9] = '{3'b100,  1, 8'h01, 8'h00, MODE12 ? 8'h12 : 8'h00, 1'b0, 0, 0};

    repeat (3) @(negedge clk);
    chk_en = 1'b1;
    chk("rst_second", second, 8'h00);
    chk("rst_minute", minute, 8'h00);
    chk("rst_hour",   hour,   h0);
    chk("rst_pm",     pm,     1'b0);

    // Single step: request high for 5 cycles, count moves on the third edge after sampling.
    rst = 1'b1;
    @(negedge clk);
    clk_s = 1'b1;
    repeat (3) @(negedge clk);
    chk("step_before_latency", second, 8'h00);
    @(negedge clk);
    chk("step_at_latency", second, 8'h01);
    @(negedge clk);
    clk_s = 1'b0;
    repeat (6) @(negedge clk);
    chk("step_held_once", second, 8'h01);

    for (int i = 0; i < 10; i++) begin
      sb_cnt = 0;
      mb_cnt = 0;
      repeat (tbl[i].reps) pulse(tbl[i].req);
      repeat (4) @(negedge clk);
      chk($sformatf("tbl%0d_second", i), second, tbl[i].sec);
      chk($sformatf("tbl%0d_minute", i), minute, tbl[i].min);
      chk($sformatf("tbl%0d_hour", i),   hour,   tbl[i].hr);
      chk($sformatf("tbl%0d_pm", i),     pm,     tbl[i].pmv);
      chk($sformatf("tbl%0d_s_bit_cycles", i), sb_cnt, tbl[i].sb);
      chk($sformatf("tbl%0d_m_bit_cycles", i), mb_cnt, tbl[i].mb);
    end

    // Reset mid-count: outputs clear without a clock edge; a held request must not count.
    repeat (36) pulse(3'b001);
    repeat (4) @(negedge clk);
    chk("pre_reset_second", second, 8'h37);
    #2 rst = 1'b0;
    #1;
    chk("async_rst_second", second, 8'h00);
    chk("async_rst_minute", minute, 8'h00);
    chk("async_rst_hour",   hour,   h0);
    chk("async_rst_s_bit",  s_bit,  1'b0);
    chk("async_rst_m_bit",  m_bit,  1'b0);
    chk("async_rst_pm",     pm,     1'b0);
    @(negedge clk);
    clk_s = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (8) @(negedge clk);
    chk("held_through_release", second, 8'h00);
    clk_s = 1'b0;
    repeat (2) @(negedge clk);
    clk_s = 1'b1;
    repeat (2) @(negedge clk);
    clk_s = 1'b0;
    repeat (4) @(negedge clk);
    chk("fresh_edge_counts", second, 8'h01);

    // Random request levels on all three inputs, checked every cycle by the model.
    repeat (2000) begin
      set_req(3'($urandom_range(0, 7)));
      @(negedge clk);
    end
    set_req(3'b000);
    repeat (6) @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/time_keeper.md
TIME_KEEPER -- requirements
Module: time_keeper

Interface
REQ-001 The block SHALL have these ports, one per line, with name, direction, width and meaning:
  clk  input  1  system clock; all state updates on rising edge.
  rst  input  1  asynchronous active-low reset.
  clk_s  input  1  second-advance request (level); each rising edge = +1 second.
  clk_m  input  1  minute-advance request (level); each rising edge = +1 minute.
  clk_h  input  1  hour-advance request (level); each rising edge = +1 hour.
  second  output  8  packed BCD seconds, 00-59.
  minute  output  8  packed BCD minutes, 00-59.
  hour  output  8  packed BCD hours, 00-23 (01-12 with TK_12H_EN).
  s_bit  output  1  seconds-wrap carry pulse.
  m_bit  output  1  minutes-wrap carry pulse.
  pm  output  1  PM flag; constant 0 without TK_12H_EN.

Function
REQ-002 clk_s, clk_m and clk_h SHALL each pass through a 2-flop synchronizer and then a rising-edge detector; the result is a one-cycle internal increment strobe.
REQ-003 The output latency SHALL be 3 clk cycles: the count updates on the 3rd rising clk edge after the edge that first samples the input high.
REQ-004 Each counter SHALL increment exactly once per input rising edge, regardless of how long the input stays high.
REQ-005 The seconds counter SHALL use BCD arithmetic: low digit 9 goes to 0 and increments the high digit; 59 goes to 00.
REQ-006 On the 59->00 seconds wrap, s_bit SHALL be high for exactly the one cycle in which second shows 00.
REQ-007 The minutes counter SHALL behave identically to the seconds counter, with m_bit as its carry.
REQ-008 The block SHALL NOT cascade internally: a seconds wrap SHALL NOT change minute, and a minutes wrap SHALL NOT change hour. Carry routing back to clk_m/clk_h is done outside the block.
REQ-009 Hours (24h mode) SHALL use BCD arithmetic, 23 goes to 00, and the wrap SHALL produce no carry output.
REQ-010 Counters SHALL be independent: simultaneous strobes on any combination SHALL each increment their own counter in the same cycle.
REQ-011 Outputs SHALL always hold valid BCD; no digit value A-F is reachable.
REQ-012 All outputs SHALL be registered, with no combinational path from input to output.

Reset
REQ-013 While rst=0, outputs SHALL be forced asynchronously to: second=00, minute=00, hour=00 (12 with TK_12H_EN), s_bit=0, m_bit=0, pm=0.
REQ-014 Synchronizer and edge-detector flops SHALL reset to 1, so an input held high across reset release produces no increment.
REQ-015 Reset asserted mid-operation SHALL discard any pending strobe; the first count after release requires a fresh 0->1 input transition.

Configuration
REQ-016 With TK_12H_EN defined, the hour counter SHALL behave as follows:
  count 01-12, 12 goes to 01;
  pm SHALL toggle on the 11->12 transition;
  reset value hour=12, pm=0.
REQ-017 Without TK_12H_EN, REQ-009 applies, pm SHALL be tied to 0, and no 12h logic is synthesized.

Structure
REQ-018 Shared package tk_pkg SHALL hold the constants:
  SEC_MAX=8'h59, MIN_MAX=8'h59, HR24_MAX=8'h23;
  HR12_MAX=8'h12, HR12_MIN=8'h01;
  SYNC_STAGES=2.
REQ-019 Sub-module bcd_counter SHALL provide the shared counter logic:
  parameters: MIN and MAX values and reset value;
  inputs: inc strobe;
  outputs: 8-bit BCD value and one-cycle wrap pulse;
  instantiated for seconds, minutes and hours;
  the 12h pm toggle lives in time_keeper.

Verification
REQ-020 The bench SHALL cover these directed scenarios:
  Single-step: release reset, pulse clk_s high for 5 cycles -> second 00->01 exactly 3 cycles after first sample; no further change.
  Digit carry: 10 clk_s pulses from 00 -> second=8'h10, s_bit never high.
  Seconds wrap: second=59, one clk_s pulse -> second=00, s_bit high exactly 1 cycle, minute unchanged.
  Minutes wrap: minute=59, one clk_m pulse -> minute=00, m_bit high 1 cycle, hour unchanged. Simultaneous clk_s+clk_m edges -> both increment in the same cycle.
  Hour wrap: hour=23, clk_h pulse -> 00 in 24h. With TK_12H_EN: 11->12 sets pm=1; 12->01 leaves pm=1.
  Reset mid-count: assert rst at second=37 -> all outputs 0 with no clk edge. clk_s held high through release -> second stays 00 until clk_s goes low then high.
